// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared FND glyph table, blank code and scan divider helper
package fnd_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam int         DP_BIT    = 7;

   // Active-low {dp,g,f,e,d,c,b,a}; entries 10..15 are the hex glyphs A,b,C,d,E,F.
   localparam logic [7:0] GLYPH [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic int fnd_div(input int clk_freq, input int scan_hz, input int num_digits);
      return clk_freq / (scan_hz * num_digits);
   endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// rtl/fnd_scan_ctrl_if.sv - digit/control inputs and FND pin outputs of the scan controller
interface fnd_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] i_digits;
   logic [NUM_DIGITS-1:0]   i_dp;
   logic [NUM_DIGITS-1:0]   i_blink;
   logic                    i_load;
   logic                    i_lz_en;
   logic [3:0]              i_bright;
   logic [7:0]              fnd_data;
   logic [NUM_DIGITS-1:0]   fnd_com;
   logic                    frame_done;

   modport master (
      output i_digits, i_dp, i_blink, i_load, i_lz_en, i_bright,
      input  fnd_data, fnd_com, frame_done
   );

   modport slave (
      input  i_digits, i_dp, i_blink, i_load, i_lz_en, i_bright,
      output fnd_data, fnd_com, frame_done
   );
endinterface

// File: rtl/fnd_seg_decode.sv
// rtl/fnd_seg_decode.sv - 4-bit code to active-low segments; blank hides the numeral only
module fnd_seg_decode
   import fnd_pkg::*;
#(
   parameter int HEX_MODE = 0
) (
   input  logic [3:0] code,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (HEX_MODE != 0 || code < 4'd10)) begin
         seg = GLYPH[code];
      end
      if (dp) begin
         seg[DP_BIT] = 1'b0;
      end
   end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - multiplexed common-anode FND driver with double buffer,
// leading-zero blanking, blink and PWM brightness
module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_FREQ     = 100_000_000,
   parameter int SCAN_HZ      = 250,
   parameter int BLINK_FRAMES = 125,
   parameter int HEX_MODE     = 0
) (
   input  logic              clk,
   input  logic              rst,
   fnd_scan_ctrl_if.slave    bus
);

   localparam int DIV = fnd_div(CLK_FREQ, SCAN_HZ, NUM_DIGITS);
   localparam int SW  = $clog2(DIV);
   localparam int DW  = $clog2(NUM_DIGITS);
   localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SW+4:0] DIV_W = (SW+5)'(DIV);

   if (DIV < 16 || NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_cfg
      $error("fnd_scan_ctrl: need DIV >= 16 and NUM_DIGITS in 2..8");
   end

   logic [SW-1:0]           slot_cnt;
   logic [DW-1:0]           sel;
   logic [FW-1:0]           frame_cnt;
   logic                    blink_phase;
   logic                    pending;
   logic [4*NUM_DIGITS-1:0] shadow_digits, active_digits;
   logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
   logic                    slot_tick, frame_end;

   assign slot_tick = (slot_cnt == SW'(DIV - 1));
   assign frame_end = slot_tick && (sel == DW'(NUM_DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt    <= '0;
         sel         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else begin
         slot_cnt <= slot_tick ? '0 : slot_cnt + 1'b1;
         if (slot_tick) begin
            sel <= (sel == DW'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
         end
         if (frame_end) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // A load landing on the frame boundary bypasses the shadow so it is shown next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending       <= 1'b0;
         shadow_digits <= '0;
         shadow_dp     <= '0;
         active_digits <= '0;
         active_dp     <= '0;
      end else begin
         if (bus.i_load) begin
            shadow_digits <= bus.i_digits;
            shadow_dp     <= bus.i_dp;
         end
         if (frame_end && bus.i_load) begin
            active_digits <= bus.i_digits;
            active_dp     <= bus.i_dp;
            pending       <= 1'b0;
         end else if (frame_end && pending) begin
            active_digits <= shadow_digits;
            active_dp     <= shadow_dp;
            pending       <= 1'b0;
         end else if (bus.i_load) begin
            pending <= 1'b1;
         end
      end
   end

   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  lz_run;

   always_comb begin
      lz_blank = '0;
      lz_run   = bus.i_lz_en;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run      = lz_run && (active_digits[4*i +: 4] == 4'd0) && !active_dp[i];
         lz_blank[i] = lz_run;
      end
   end

   logic [3:0] cur_code;
   logic       blink_off;
   logic [7:0] seg;

   assign cur_code  = active_digits[4*sel +: 4];
   assign blink_off = bus.i_blink[sel] && !blink_phase;

   fnd_seg_decode #(
      .HEX_MODE (HEX_MODE)
   ) u_decode (
      .code  (cur_code),
      .dp    (active_dp[sel] && !blink_off),
      .blank (lz_blank[sel] || blink_off),
      .seg   (seg)
   );

   // on_len is floored at 2 so the dimmest level still lights one cycle after the guard slot.
   logic [SW+4:0] bright_prod;
   logic [SW:0]   on_len, on_eff;
   logic          lit;

   assign bright_prod = (SW+5)'({1'b0, bus.i_bright} + 5'd1) * DIV_W;
   assign on_len      = (SW+1)'(bright_prod >> 4);
   assign on_eff      = (on_len < (SW+1)'(2)) ? (SW+1)'(2) : on_len;
   assign lit         = (slot_cnt != '0) && ({1'b0, slot_cnt} < on_eff);

   logic [NUM_DIGITS-1:0] com_q;
   logic [7:0]            data_q;
   logic                  frame_done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         com_q        <= '1;
         data_q       <= SEG_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= frame_end;
         if (lit) begin
            com_q  <= ~(NUM_DIGITS'(1) << sel);
            data_q <= seg;
         end else begin
            com_q  <= '1;
            data_q <= SEG_BLANK;
         end
      end
   end

   assign bus.fnd_com    = com_q;
   assign bus.fnd_data   = data_q;
   assign bus.frame_done = frame_done_q;

endmodule
